// File: rtl/tick_sched_pkg.sv
// Shared types for the tick scheduler: per-channel run state.
// Pure declarations, no logic.
package tick_sched_pkg;
  typedef enum logic {
    CH_IDLE = 1'b0,
    CH_RUN  = 1'b1
  } ch_state_t;
endpackage

// File: rtl/tick_channel.sv
// One scheduler channel: down-counts base ticks and pulses tick at terminal count.
// tick lands one cycle after the terminal base_tick; writes are never stalled here.
module tick_channel
  import tick_sched_pkg::*;
#(
  parameter int CNT_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             base_tick,
  input  logic             wr_en,
  input  logic             wr_start,
  input  logic             wr_oneshot,
  input  logic [CNT_W-1:0] wr_period,
  output logic             tick,
  output logic             active
);

  ch_state_t        state;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] shadow_period;
  logic             oneshot;
  logic             shadow_oneshot;
  logic             shadow_vld;

  assign active = (state == CH_RUN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= CH_IDLE;
      period         <= '0;
      cnt            <= '0;
      oneshot        <= 1'b0;
      shadow_period  <= '0;
      shadow_oneshot <= 1'b0;
      shadow_vld     <= 1'b0;
      tick           <= 1'b0;
    end else begin
      tick <= 1'b0;
      if (wr_en && !wr_start) begin
        // A stop overrides a coincident terminal event, so no tick is emitted.
        state      <= CH_IDLE;
        cnt        <= '0;
        shadow_vld <= 1'b0;
      end else begin
        if (state == CH_RUN && base_tick) begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            tick <= 1'b1;
            if (shadow_vld) begin
              period     <= shadow_period;
              oneshot    <= shadow_oneshot;
              cnt        <= shadow_period - 1'b1;
              shadow_vld <= 1'b0;
            end else if (oneshot) begin
              state <= CH_IDLE;
            end else begin
              cnt <= period - 1'b1;
            end
          end
        end
        // Placed after the terminal logic so a reload coinciding with a terminal
        // becomes the new pending shadow rather than being lost.
        if (wr_en) begin
          if (state == CH_IDLE) begin
            state      <= CH_RUN;
            period     <= wr_period;
            oneshot    <= wr_oneshot;
            cnt        <= wr_period - 1'b1;
            shadow_vld <= 1'b0;
          end else begin
            shadow_period  <= wr_period;
            shadow_oneshot <= wr_oneshot;
            shadow_vld     <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/tick_scheduler.sv
// Shared prescaler feeding NUM_CH tick channels, with a valid/ready config port.
// Config accepted at most every other cycle (ready drops one cycle per accept).
module tick_scheduler #(
  parameter  int NUM_CH   = 4,
  parameter  int CNT_W    = 24,
  parameter  int PRESCALE = 25,
  localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_period,
  input  logic              cfg_oneshot,
  input  logic              cfg_start,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] active,
  output logic              cfg_err
);

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PS_W-1:0]   ps_cnt;
  logic              base_tick;
  logic              accept;
  logic              ch_ok;
  logic              bad_period;
  logic              cfg_good;
  logic [NUM_CH-1:0] ch_hit;
  logic [NUM_CH-1:0] wr_en;

  assign base_tick = (ps_cnt == PS_W'(PRESCALE - 1));

  always_ff @(posedge clk) begin
    if (rst || base_tick) begin
      ps_cnt <= '0;
    end else begin
      ps_cnt <= ps_cnt + 1'b1;
    end
  end

  // One-hot decode; an encoding with no matching channel is out of range.
  always_comb begin
    ch_hit = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      ch_hit[i] = (cfg_ch == CH_W'(i));
    end
  end

  assign accept     = cfg_valid && cfg_ready;
  assign ch_ok      = |ch_hit;
  assign bad_period = cfg_start && (cfg_period == '0);
  assign cfg_good   = accept && ch_ok && !bad_period;
  assign wr_en      = cfg_good ? ch_hit : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_ready <= 1'b1;
      cfg_err   <= 1'b0;
    end else begin
      cfg_ready <= !accept;
      cfg_err   <= accept && !cfg_good;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    tick_channel #(
      .CNT_W(CNT_W)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .base_tick (base_tick),
      .wr_en     (wr_en[g]),
      .wr_start  (cfg_start),
      .wr_oneshot(cfg_oneshot),
      .wr_period (cfg_period),
      .tick      (tick[g]),
      .active    (active[g])
    );
  end

endmodule

// File: tb/tb_tick_scheduler.sv
// Directed bench for tick_scheduler (2 channels, 8-bit counters, prescale 4).
// A 3-channel instance is used only for the out-of-range channel case.
module tb_tick_scheduler;
  localparam int NUM_CH   = 2;
  localparam int CNT_W    = 8;
  localparam int PRESCALE = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cfg_valid;
  logic              cfg_valid3;
  logic [1:0]        cfg_ch;
  logic [CNT_W-1:0]  cfg_period;
  logic              cfg_oneshot;
  logic              cfg_start;
  logic              cfg_ready;
  logic              cfg_err;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] active;
  logic              ready3;
  logic              err3;
  logic [2:0]        tick3;
  logic [2:0]        active3;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  int rst_edge;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  tick_scheduler #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .PRESCALE(PRESCALE)) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch[0:0]), .cfg_period(cfg_period), .cfg_oneshot(cfg_oneshot),
    .cfg_start(cfg_start), .tick(tick), .active(active), .cfg_err(cfg_err)
  );

  tick_scheduler #(.NUM_CH(3), .CNT_W(CNT_W), .PRESCALE(PRESCALE)) dut3 (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid3), .cfg_ready(ready3),
    .cfg_ch(cfg_ch), .cfg_period(cfg_period), .cfg_oneshot(cfg_oneshot),
    .cfg_start(cfg_start), .tick(tick3), .active(active3), .cfg_err(err3)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  // Base ticks fall in cycles n with (n - last reset edge) mod PRESCALE == PRESCALE-1;
  // the P-th one at or after the accepting edge is terminal, tick shows one cycle later.
  function automatic int first_tick(int re, int acc, int p);
    int n = acc;
    while (((n - re) % PRESCALE) != PRESCALE - 1) n++;
    return n + PRESCALE * (p - 1) + 1;
  endfunction

  task automatic wr(input int ch, input int p, input bit os, input bit st, output int acc);
    @(posedge clk); #1;
    cfg_valid = 1'b1; cfg_ch = 2'(ch); cfg_period = CNT_W'(p);
    cfg_oneshot = os; cfg_start = st;
    for (int i = 0; i < 8 && !cfg_ready; i++) begin @(posedge clk); #1; end
    chk("wr_ready", int'(cfg_ready), 1);
    @(posedge clk); #1;
    acc = cyc;
    cfg_valid = 1'b0;
  endtask

  task automatic wait_tick(input int ch, input int budget, output int t);
    t = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (tick[ch]) begin t = cyc; break; end
    end
  endtask

  initial begin
    int a, t, t1, t2, t3, t4, t5, t6, ta, tb, lat0;
    cfg_valid = 0; cfg_valid3 = 0; cfg_ch = 0; cfg_period = 0;
    cfg_oneshot = 0; cfg_start = 0;
    repeat (2) @(posedge clk);
    #1; rst = 1'b0; rst_edge = cyc;
    chk("rst_tick", int'(tick), 0);
    chk("rst_active", int'(active), 0);
    chk("rst_err", int'(cfg_err), 0);
    chk("rst_ready", int'(cfg_ready), 1);

    // Periodic, P=3: 12-cycle spacing.
    wr(0, 3, 0, 1, a);
    chk("per_active", int'(active[0]), 1);
    wait_tick(0, 20, t1);
    chk("per_first", t1, first_tick(rst_edge, a, 3));
    lat0 = t1 - a;
    wait_tick(0, 20, t2); chk("per_int1", t2 - t1, 12);
    wait_tick(0, 20, t3); chk("per_int2", t3 - t2, 12);
    chk("per_active2", int'(active[0]), 1);

    // Reload to P=5 mid-interval: current interval finishes, then 20 cycles.
    wr(0, 5, 0, 1, a);
    wait_tick(0, 20, t4); chk("rel_old", t4 - t3, 12);
    wait_tick(0, 30, t5); chk("rel_new1", t5 - t4, 20);
    wait_tick(0, 30, t6); chk("rel_new2", t6 - t5, 20);

    // Stop accepted in the terminal base_tick cycle (cycle t6+19).
    while (cyc < t6 + 19) begin @(posedge clk); #1; end
    cfg_valid = 1'b1; cfg_ch = 0; cfg_start = 1'b0; cfg_period = 5;
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    chk("stop_tick", int'(tick[0]), 0);
    chk("stop_active", int'(active[0]), 0);
    wait_tick(0, 40, t); chk("stop_none", t, -1);

    // One-shot on ch1, P=2.
    wr(1, 2, 1, 1, a);
    wait_tick(1, 12, t);
    chk("os_first", t, first_tick(rst_edge, a, 2));
    chk("os_active", int'(active[1]), 0);
    wait_tick(1, 100, t); chk("os_none", t, -1);

    // Start with P=0 on an idle channel.
    wr(0, 0, 0, 1, a);
    chk("p0_err", int'(cfg_err), 1);
    chk("p0_active", int'(active[0]), 0);
    @(posedge clk); #1;
    chk("p0_err_clr", int'(cfg_err), 0);

    // Channel 2 on the 3-channel instance is in range; encoding 3 is not.
    @(posedge clk); #1;
    chk("oob_ready", int'(ready3), 1);
    cfg_valid3 = 1'b1; cfg_ch = 2'd3; cfg_period = 3; cfg_start = 1'b1; cfg_oneshot = 1'b0;
    @(posedge clk); #1;
    cfg_valid3 = 1'b0;
    chk("oob_err", int'(err3), 1);
    chk("oob_active", int'(active3), 0);
    @(posedge clk); #1;
    chk("oob_err_clr", int'(err3), 0);
    chk("oob_tick", int'(tick3), 0);

    // Start with P=0 on a running channel leaves it untouched.
    wr(1, 2, 0, 1, a);
    wait_tick(1, 12, ta);
    wr(1, 0, 0, 1, a);
    chk("p0run_err", int'(cfg_err), 1);
    chk("p0run_active", int'(active[1]), 1);
    wait_tick(1, 12, tb); chk("p0run_int", tb - ta, 8);

    // Held valid: ready alternates 1/0.
    @(posedge clk); #1;
    cfg_valid = 1'b1; cfg_ch = 0; cfg_start = 1'b0; cfg_period = 0;
    for (int i = 0; i < 6; i++) begin
      chk("hold_ready", int'(cfg_ready), (i % 2 == 0) ? 1 : 0);
      @(posedge clk); #1;
    end
    cfg_valid = 1'b0;
    chk("hold_err", int'(cfg_err), 0);

    // Reset with both channels running.
    wr(0, 3, 0, 1, a);
    chk("mid_active", int'(active), 3);
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0; rst_edge = cyc;
    chk("mid_tick", int'(tick), 0);
    chk("mid_active0", int'(active), 0);
    chk("mid_ready", int'(cfg_ready), 1);
    wr(0, 3, 0, 1, a);
    wait_tick(0, 20, t);
    chk("mid_first", t, first_tick(rst_edge, a, 3));
    chk("mid_lat", t - a, lat0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1);
  end

endmodule

// File: doc/tick_scheduler.md
# tick_scheduler

Multi-channel tick scheduler that shares one free-running prescaler among NUM_CH independently programmable channels. Each channel emits single-cycle `tick` enable pulses, periodic or one-shot. Consumers use these pulses as clock enables on `clk`, never as derived clocks. Channels are configured at runtime through a valid/ready write port, and period changes on a running channel take effect only at its next terminal count.

## Interface
- `NUM_CH`, 4, number of channels (≥1)
- `CNT_W`, 24, width of the per-channel period counter
- `PRESCALE`, 25, `clk` cycles per base tick (≥1); 25 MHz gives a 1 MHz base

- `clk`  in  1  system clock; the only clock
- `rst`  in  1  synchronous, active-high reset
- `cfg_valid`  in  1  configuration write request
- `cfg_ready`  out  1  write accepted when `cfg_valid && cfg_ready`
- `cfg_ch`  in  $clog2(NUM_CH) (min 1)  target channel
- `cfg_period`  in  CNT_W  period in base ticks
- `cfg_oneshot`  in  1  0 = periodic, 1 = one-shot
- `cfg_start`  in  1  1 = start/reload, 0 = stop
- `tick`  out  NUM_CH  one-cycle pulse per channel event
- `active`  out  NUM_CH  channel in RUN
- `cfg_err`  out  1  one-cycle pulse: rejected write

## Operation
- **Prescaler:** counts 0..PRESCALE-1 and wraps. `base_tick` is high in the cycle where count == PRESCALE-1. It runs regardless of channel state. With PRESCALE=1, `base_tick` is high every cycle.
- **Per-channel FSM states:**
  - `CH_IDLE`
  - `CH_RUN`
- **Per-channel registers:**
  - `period`, `oneshot`
  - down-counter `cnt`
  - `shadow_period`, `shadow_oneshot`, `shadow_vld`
- **Accepted write, start=1, period=0:** rejected; `cfg_err` pulses; channel is unchanged.
- **Accepted write, start=1, period P>0, channel IDLE:**
  - `period` ← P, `cnt` ← P-1.
  - Channel enters RUN.
- **Accepted write, start=1, channel RUN:**
  - Values go to the shadow registers and `shadow_vld` ← 1.
  - A newer write overwrites a pending shadow.
- **Accepted write, start=0:**
  - Channel goes to IDLE immediately.
  - `cnt` ← 0, `shadow_vld` ← 0.
  - Not an error in any state.
- **RUN and `base_tick`:**
  - If `cnt` ≠ 0: `cnt` decrements.
  - If `cnt` == 0, this is the terminal event and `tick[i]` pulses.
  - On terminal, periodic: if `shadow_vld`, load the shadow values into `period`/`oneshot`, set `cnt` ← shadow_period-1, clear `shadow_vld`. Otherwise set `cnt` ← period-1.
  - On terminal, one-shot without a pending shadow: go to IDLE.
  - On terminal, one-shot with a pending shadow: apply the shadow as in the periodic case and stay in RUN.
- **Handshake:** `cfg_ready` drops for exactly the one cycle after each accepted write. Maximum write rate is one per 2 cycles. `cfg_ready` is independent of channel state.
- **Simultaneous events:**
  - Stop accepted in the same cycle as a terminal event: stop wins, no tick.
  - Reload accepted in the same cycle as a terminal event: it is not applied to this reload; it becomes the shadow and applies at the following terminal.
  - Out-of-range `cfg_ch` (≥ NUM_CH): rejected with `cfg_err`.
- **Reset mid-operation:** all channels go to IDLE, shadows are cleared, the prescaler goes to 0. Any in-flight write is dropped.

## Timing
- **Reset values:**
  - `tick` = 0, `active` = 0, `cfg_err` = 0.
  - `cfg_ready` = 1.
  - Prescaler count = 0.
- All outputs are registered.
- `active[i]` rises the cycle after a start write is accepted.
- `active[i]` falls the cycle after a stop is accepted, or in the same cycle `tick[i]` is high for a one-shot terminal.
- `tick[i]` is high the cycle after the `base_tick` cycle carrying the terminal event.
- Steady-state interval between ticks = P × PRESCALE `clk` cycles exactly.
- First-tick latency after a start accepted in cycle t falls in [(P-1)×PRESCALE+2, P×PRESCALE+1] cycles, depending on prescaler phase.
- `cfg_err` is high the cycle after the rejected accept.
- Counters wrap never: `cnt` loads ≤ 2^CNT_W-2.

## Structure
- **Package `tick_sched_pkg`:** `ch_state_t` enum {`CH_IDLE`, `CH_RUN`}.
- **Sub-module `tick_channel`:**
  - Inputs: `clk`, `rst`, `base_tick`, decoded write strobe plus fields.
  - Outputs: `tick`, `active`.
  - Instantiated NUM_CH times with a generate loop.
- **Top level holds:** prescaler, `cfg_ready`/`cfg_err` logic, channel decode.

## Test plan
Bench parameters: NUM_CH=2, CNT_W=8, PRESCALE=4.
- **Periodic:** ch0 start, P=3, periodic → `tick[0]` every 12 cycles; `active[0]` stays 1.
- **One-shot:** ch1 start, P=2, one-shot → exactly one `tick[1]` (at the latest 9 cycles after accept); `active[1]` drops in the same cycle; no further ticks over 100 cycles.
- **Reload while running:** ch0 running P=3; write P=5 mid-interval → current 12-cycle interval completes unchanged, then 20-cycle intervals.
- **Stop at terminal:** stop on ch0 accepted in the terminal `base_tick` cycle → no `tick[0]`; `active[0]` = 0 next cycle.
- **Rejected writes and handshake:** start with P=0, and a write with `cfg_ch`=2 → each gives a one-cycle `cfg_err` pulse with channel state unchanged. Held `cfg_valid` → `cfg_ready` alternates 1/0 and accepts every second cycle.
- **Reset mid-run:** assert `rst` for 1 cycle with both channels running → next cycle all `tick`/`active` = 0, `cfg_ready` = 1; a new start gives the same first-tick latency as after power-up.
